// File: rtl/stream_to_multi_symbols_pkg.sv
// rtl/stream_to_multi_symbols_pkg.sv - shared FSM state and beat-index width helper
package stream_to_multi_symbols_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A single-beat configuration still needs a one-bit index port.
    function automatic int beat_idx_width(input int num_beats);
        return (num_beats > 1) ? $clog2(num_beats) : 1;
    endfunction

endpackage

// File: rtl/stream_to_multi_symbols_symbol_extend.sv
// rtl/stream_to_multi_symbols_symbol_extend.sv - combinational zero/sign extender for one symbol
module symbol_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 17
) (
    input  logic [IN_W-1:0]  sym,
    input  logic             sign_en,
    output logic [OUT_W-1:0] ext
);

    always_comb begin
        ext            = {OUT_W{sign_en & sym[IN_W-1]}};
        ext[IN_W-1:0]  = sym;
    end

endmodule

// File: rtl/stream_to_multi_symbols.sv
// rtl/stream_to_multi_symbols.sv - splits a wide integer into radix symbols emitted as multi-symbol beats
module stream_to_multi_symbols
    import stream_to_multi_symbols_pkg::*;
#(
    parameter int INPUTBITWIDTH        = 1024,
    parameter int NUMSYMBOLS           = 66,
    parameter int LOGRADIX             = 16,
    parameter int OUTPUTSYMBOLBITWIDTH = 17,
    parameter int SYMBOLSPERBEAT       = 6,
    localparam int NUMBEATS            = NUMSYMBOLS / SYMBOLSPERBEAT,
    localparam int BEATW               = beat_idx_width(NUMBEATS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INPUTBITWIDTH-1:0]        data_in,
    input  logic                            in_signed,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUTPUTSYMBOLBITWIDTH-1:0] out_data [SYMBOLSPERBEAT],
    output logic [BEATW-1:0]                out_beat,
    output logic                            out_last
);

    localparam int TOTALBITS = NUMSYMBOLS * LOGRADIX;
    localparam int BEATBITS  = SYMBOLSPERBEAT * LOGRADIX;
    localparam logic [BEATW-1:0] LASTBEAT = BEATW'(NUMBEATS - 1);

    generate
        if ((NUMSYMBOLS % SYMBOLSPERBEAT) != 0 || LOGRADIX > OUTPUTSYMBOLBITWIDTH ||
            TOTALBITS < INPUTBITWIDTH) begin : g_bad_params
            $error("stream_to_multi_symbols: inconsistent parameters");
        end
    endgenerate

    state_t                 state;
    logic [TOTALBITS-1:0]   data_q;
    logic [TOTALBITS-1:0]   ext;
    logic                   signed_q;
    logic [BEATW-1:0]       beat_q;
    logic                   send;
    logic                   out_hs;
    logic                   accept;

    always_comb begin
        ext                      = {TOTALBITS{in_signed & data_in[INPUTBITWIDTH-1]}};
        ext[INPUTBITWIDTH-1:0]   = data_in;
    end

    assign send      = (state == ST_SEND);
    assign out_valid = send;
    assign out_beat  = beat_q;
    assign out_last  = send && (beat_q == LASTBEAT);
    assign out_hs    = out_valid && out_ready;
    // Accepting during the last-beat handshake keeps beats flowing without a bubble.
    assign in_ready  = !send || (out_hs && out_last);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            signed_q <= 1'b0;
            beat_q   <= '0;
        end else if (accept) begin
            state    <= ST_SEND;
            data_q   <= ext;
            signed_q <= in_signed;
            beat_q   <= '0;
        end else if (out_hs) begin
            data_q <= data_q >> BEATBITS;
            if (out_last) begin
                state  <= ST_IDLE;
                beat_q <= '0;
            end else begin
                beat_q <= beat_q + BEATW'(1);
            end
        end
    end

    // The current beat always sits in the low bits of the shift register.
    for (genvar j = 0; j < SYMBOLSPERBEAT; j++) begin : g_sym
        symbol_extend #(
            .IN_W  (LOGRADIX),
            .OUT_W (OUTPUTSYMBOLBITWIDTH)
        ) u_symbol_extend (
            .sym     (data_q[j*LOGRADIX +: LOGRADIX]),
            .sign_en (signed_q && out_last && (j == SYMBOLSPERBEAT - 1)),
            .ext     (out_data[j])
        );
    end

endmodule
